// File: rtl/div_pkg.sv
// Shared widths, request layout and approximation-mask constants for the
// divider issue controller.
package div_pkg;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;
  localparam int QUOT_W     = 4;
  localparam int ACC_W      = 2;
  localparam int MASK_W     = 16;
  localparam int REQ_W      = DIVIDEND_W + DIVISOR_W + ACC_W;

  localparam logic [MASK_W-1:0] ACC_MASK_0 = 16'h0000;
  localparam logic [MASK_W-1:0] ACC_MASK_1 = 16'h1111;
  localparam logic [MASK_W-1:0] ACC_MASK_2 = 16'h3333;
  localparam logic [MASK_W-1:0] ACC_MASK_3 = 16'h7777;

  localparam logic [QUOT_W-1:0] DBZ_QUOT = 4'hF;

  typedef struct packed {
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic [ACC_W-1:0]      acc;
  } div_req_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  // Each level enables one more low-order cell per quotient row.
  function automatic logic [MASK_W-1:0] acc_to_mask(input logic [ACC_W-1:0] acc);
    case (acc)
      2'd0:    return ACC_MASK_0;
      2'd1:    return ACC_MASK_1;
      2'd2:    return ACC_MASK_2;
      default: return ACC_MASK_3;
    endcase
  endfunction

endpackage

// File: rtl/div_req_fifo.sv
// In-order request FIFO with a combinational head view; the head reads as
// zero while empty so downstream array inputs stay quiet.
module div_req_fifo
  import div_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [REQ_W-1:0] push_data,
  input  logic             pop,
  output logic [REQ_W-1:0] head_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [REQ_W-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// Feeds queued divide requests to an external approximate array divider and
// captures its answer, with divide-by-zero/overflow screening, into a result slot.
module div_issue_ctrl
  import div_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int EXC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_dividend,
  input  logic [3:0]       in_divisor,
  input  logic [1:0]       in_acc,
  output logic [7:0]       arr_x,
  output logic [3:0]       arr_y,
  output logic [15:0]      arr_a,
  input  logic [3:0]       arr_q,
  input  logic [3:0]       arr_r,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_q,
  output logic [3:0]       out_r,
  output logic             out_ovf,
  output logic             out_dbz,
  output logic [1:0]       out_acc,
  output logic [EXC_W-1:0] cnt_exc
);

  logic [REQ_W-1:0] push_data;
  logic [REQ_W-1:0] head_data;
  div_req_t         head;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             load;
  logic             drain;

  slot_state_t       slot_q, slot_d;
  logic [QUOT_W-1:0] out_q_q, out_q_d;
  logic [QUOT_W-1:0] out_r_q, out_r_d;
  logic              out_ovf_q, out_ovf_d;
  logic              out_dbz_q, out_dbz_d;
  logic [ACC_W-1:0]  out_acc_q, out_acc_d;
  logic [EXC_W-1:0]  cnt_exc_q, cnt_exc_d;

  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready;
  assign push_data = {in_dividend, in_divisor, in_acc};
  assign head      = div_req_t'(head_data);

  div_req_fifo #(
    .DEPTH(DEPTH)
  ) u_req_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_data),
    .pop      (load),
    .head_data(head_data),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign arr_x = head.dividend;
  assign arr_y = head.divisor;
  assign arr_a = fifo_empty ? '0 : acc_to_mask(head.acc);

  assign out_valid = (slot_q == SLOT_FULL);
  assign drain     = out_valid && out_ready;
  // A full slot can be refilled in the same cycle it is drained.
  assign load      = !fifo_empty && ((slot_q == SLOT_EMPTY) || out_ready);

  always_comb begin
    slot_d    = slot_q;
    out_q_d   = out_q_q;
    out_r_d   = out_r_q;
    out_ovf_d = out_ovf_q;
    out_dbz_d = out_dbz_q;
    out_acc_d = out_acc_q;
    if (load) begin
      slot_d    = SLOT_FULL;
      out_acc_d = head.acc;
      if (head.divisor == '0) begin
        out_q_d   = DBZ_QUOT;
        out_r_d   = '0;
        out_ovf_d = 1'b0;
        out_dbz_d = 1'b1;
      end else if (head.dividend[DIVIDEND_W-1 -: DIVISOR_W] >= head.divisor) begin
        // Quotient would need more than QUOT_W bits.
        out_q_d   = '0;
        out_r_d   = '0;
        out_ovf_d = 1'b1;
        out_dbz_d = 1'b0;
      end else begin
        out_q_d   = arr_q;
        out_r_d   = arr_r;
        out_ovf_d = 1'b0;
        out_dbz_d = 1'b0;
      end
    end else if (drain) begin
      slot_d = SLOT_EMPTY;
    end
  end

  always_comb begin
    cnt_exc_d = cnt_exc_q;
    if (drain && (out_ovf_q || out_dbz_q) && (cnt_exc_q != '1))
      cnt_exc_d = cnt_exc_q + EXC_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q    <= SLOT_EMPTY;
      out_q_q   <= '0;
      out_r_q   <= '0;
      out_ovf_q <= 1'b0;
      out_dbz_q <= 1'b0;
      out_acc_q <= '0;
      cnt_exc_q <= '0;
    end else begin
      slot_q    <= slot_d;
      out_q_q   <= out_q_d;
      out_r_q   <= out_r_d;
      out_ovf_q <= out_ovf_d;
      out_dbz_q <= out_dbz_d;
      out_acc_q <= out_acc_d;
      cnt_exc_q <= cnt_exc_d;
    end
  end

  assign out_q   = out_q_q;
  assign out_r   = out_r_q;
  assign out_ovf = out_ovf_q;
  assign out_dbz = out_dbz_q;
  assign out_acc = out_acc_q;
  assign cnt_exc = cnt_exc_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: directed scenarios plus a randomized run scored
// against a transaction-level queue model with its own toy array divider.
module tb_div_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_dividend;
  logic [3:0]  in_divisor;
  logic [1:0]  in_acc;
  logic [7:0]  arr_x;
  logic [3:0]  arr_y;
  logic [15:0] arr_a;
  logic [3:0]  arr_q;
  logic [3:0]  arr_r;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_q;
  logic [3:0]  out_r;
  logic        out_ovf;
  logic        out_dbz;
  logic [1:0]  out_acc;
  logic [7:0]  cnt_exc;

  int checks;
  int failures;
  logic [11:0] exp_q[$];

  div_issue_ctrl #(.DEPTH(2), .EXC_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor), .in_acc(in_acc),
    .arr_x(arr_x), .arr_y(arr_y), .arr_a(arr_a), .arr_q(arr_q), .arr_r(arr_r),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_r(out_r), .out_ovf(out_ovf), .out_dbz(out_dbz),
    .out_acc(out_acc), .cnt_exc(cnt_exc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Toy array divider: exact division, quotient perturbed by the row-0 mask bits.
  logic [7:0] arr_quo;
  logic [7:0] arr_rem;
  always_comb begin
    arr_quo = '0;
    arr_rem = '0;
    arr_q   = '0;
    arr_r   = '0;
    if (arr_y != 4'd0) begin
      arr_quo = arr_x / {4'd0, arr_y};
      arr_rem = arr_x % {4'd0, arr_y};
      arr_q   = arr_quo[3:0] ^ arr_a[3:0];
      arr_r   = arr_rem[3:0];
    end
  end

  // Expected {ovf, dbz, q, r} from the division rules and the toy array.
  function automatic logic [9:0] model(input logic [7:0] dvd, input logic [3:0] dvs,
                                       input logic [1:0] acc);
    int q;
    int r;
    logic [3:0] pert;
    case (acc)
      2'd0:    pert = 4'h0;
      2'd1:    pert = 4'h1;
      2'd2:    pert = 4'h3;
      default: pert = 4'h7;
    endcase
    if (dvs == 4'd0) return {1'b0, 1'b1, 4'hF, 4'h0};
    q = int'(dvd) / int'(dvs);
    r = int'(dvd) % int'(dvs);
    if (q > 15) return {1'b1, 1'b0, 8'h00};
    return {2'b00, 4'(q) ^ pert, 4'(r)};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_dividend = '0; in_divisor = '0; in_acc = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if ({cnt_exc, out_q, out_r, out_ovf, out_dbz, out_acc} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got cnt=%0d q=%0h r=%0h ovf=%b dbz=%b acc=%0d expected all 0",
               cnt_exc, out_q, out_r, out_ovf, out_dbz, out_acc);
    end
    checks++;
    if ({arr_x, arr_y, arr_a} !== '0) begin
      failures++; $display("FAIL reset_arr: got x=%0h y=%0h a=%0h expected 0", arr_x, arr_y, arr_a);
    end
    @(posedge clk); #1;
    $display("test_reset done");
  endtask

  task automatic test_exact();
    in_valid = 1'b1; in_dividend = 8'h64; in_divisor = 4'd7; in_acc = 2'd0; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || arr_x !== 8'h64 || arr_y !== 4'd7 || arr_a !== 16'h0000) begin
      failures++;
      $display("FAIL exact_head: got v=%b x=%0h y=%0h a=%0h expected v=0 x=64 y=7 a=0000",
               out_valid, arr_x, arr_y, arr_a);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_ovf, out_dbz, out_q, out_r, out_acc} !== {3'b100, 4'd14, 4'd2, 2'd0}) begin
      failures++;
      $display("FAIL exact_result: got v=%b ovf=%b dbz=%b q=%0d r=%0d acc=%0d expected v=1 q=14 r=2 flags 0",
               out_valid, out_ovf, out_dbz, out_q, out_r, out_acc);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || cnt_exc !== 8'd0) begin
      failures++; $display("FAIL exact_drain: got v=%b cnt=%0d expected v=0 cnt=0", out_valid, cnt_exc);
    end
    $display("test_exact: 0x64/7 -> q=%0d r=%0d", 14, 2);
  endtask

  task automatic test_dbz();
    in_valid = 1'b1; in_dividend = 8'h64; in_divisor = 4'd0; in_acc = 2'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_ovf, out_dbz, out_q, out_r} !== {3'b101, 4'hF, 4'h0}) begin
      failures++;
      $display("FAIL dbz_result: got v=%b ovf=%b dbz=%b q=%0h r=%0h expected v=1 dbz=1 q=f r=0",
               out_valid, out_ovf, out_dbz, out_q, out_r);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (cnt_exc !== 8'd1) begin failures++; $display("FAIL dbz_cnt: got %0d expected 1", cnt_exc); end
    $display("test_dbz: 0x64/0 delivered");
  endtask

  task automatic test_ovf();
    in_valid = 1'b1; in_dividend = 8'h80; in_divisor = 4'd7; in_acc = 2'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_ovf, out_dbz, out_q, out_r} !== {3'b110, 4'h0, 4'h0}) begin
      failures++;
      $display("FAIL ovf_result: got v=%b ovf=%b dbz=%b q=%0h r=%0h expected v=1 ovf=1 q=0 r=0",
               out_valid, out_ovf, out_dbz, out_q, out_r);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (cnt_exc !== 8'd2) begin failures++; $display("FAIL ovf_cnt: got %0d expected 2", cnt_exc); end
    $display("test_ovf: 0x80/7 delivered");
  endtask

  task automatic test_acc();
    logic [15:0] masks [4];
    logic [9:0]  want;
    masks[0] = 16'h0000; masks[1] = 16'h1111; masks[2] = 16'h3333; masks[3] = 16'h7777;
    for (int a = 1; a < 4; a++) begin
      in_valid = 1'b1; in_dividend = 8'h64; in_divisor = 4'd7; in_acc = 2'(a);
      want = model(8'h64, 4'd7, 2'(a));
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (arr_a !== masks[a]) begin
        failures++; $display("FAIL acc_mask: acc=%0d got %0h expected %0h", a, arr_a, masks[a]);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_acc !== 2'(a) || {out_ovf, out_dbz, out_q, out_r} !== want) begin
        failures++;
        $display("FAIL acc_result: acc=%0d got v=%b acc=%0d q=%0h r=%0h expected acc=%0d q=%0h r=%0h",
                 a, out_valid, out_acc, out_q, out_r, a, want[7:4], want[3:0]);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      $display("test_acc: acc=%0d mask=%0h", a, masks[a]);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] want;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_dividend = 8'(8'h10 * (i + 1)); in_divisor = 4'd5; in_acc = 2'(i);
      checks++;
      if (in_ready !== (i < 3)) begin
        failures++; $display("FAIL b2b_in_ready: req %0d got %b expected %b", i, in_ready, (i < 3));
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      want = model(8'(8'h10 * (i + 1)), 4'd5, 2'(i));
      checks++;
      if (out_valid !== 1'b1 || out_acc !== 2'(i) || {out_ovf, out_dbz, out_q, out_r} !== want) begin
        failures++;
        $display("FAIL b2b_result: idx %0d got v=%b acc=%0d q=%0h r=%0h expected acc=%0d q=%0h r=%0h",
                 i, out_valid, out_acc, out_q, out_r, i, want[7:4], want[3:0]);
      end
      $display("test_back_to_back: result %0d q=%0h r=%0h", i, out_q, out_r);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty: got v=%b expected 0", out_valid); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_dividend = 8'h23; in_divisor = 4'd3; in_acc = 2'd0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || cnt_exc !== 8'd0 || out_q !== 4'd0) begin
      failures++;
      $display("FAIL midreset_async: got v=%b rdy=%b cnt=%0d q=%0h expected v=0 rdy=1 cnt=0 q=0",
               out_valid, in_ready, cnt_exc, out_q);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        failures++; $display("FAIL midreset_stale: cycle %0d got v=%b expected 0", i, out_valid);
      end
    end
    out_ready = 1'b0;
    $display("test_reset_midflight done");
  endtask

  task automatic test_saturate();
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    int bad  = 0;
    out_ready = 1'b1;
    while (got < 256 && cyc < 400) begin
      in_valid = (sent < 256); in_dividend = 8'hF0; in_divisor = 4'(1 + (sent % 15)); in_acc = 2'd0;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        got++;
        if (out_ovf !== 1'b1) bad++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++;
    if (got !== 256 || bad !== 0) begin
      failures++; $display("FAIL sat_delivered: got %0d results (%0d non-ovf) expected 256 ovf", got, bad);
    end
    checks++;
    if (cyc > 262) begin failures++; $display("FAIL sat_throughput: got %0d cycles expected <= 262", cyc); end
    checks++;
    if (cnt_exc !== 8'd255) begin failures++; $display("FAIL sat_cnt: got %0d expected 255", cnt_exc); end
    $display("test_saturate: %0d results in %0d cycles, cnt=%0d", got, cyc, cnt_exc);
  endtask

  task automatic test_random();
    logic        prev_stall = 1'b0;
    logic [11:0] prev_out   = '0;
    logic [11:0] cur_out;
    logic [11:0] want;
    int          exc_model  = 0;
    int          delivered  = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 840; cyc++) begin
      if (cyc < 800) begin
        in_valid    = ($urandom_range(0, 9) < 7);
        in_dividend = 8'($urandom);
        in_divisor  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        in_acc      = 2'($urandom);
        out_ready   = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      cur_out = {out_acc, out_ovf, out_dbz, out_q, out_r};
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || cur_out !== prev_out) begin
          failures++;
          $display("FAIL rand_stable: cycle %0d got v=%b fields=%0h expected v=1 fields=%0h",
                   cyc, out_valid, cur_out, prev_out);
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back({in_acc, model(in_dividend, in_divisor, in_acc)});
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rand_result: cycle %0d got unexpected result %0h", cyc, cur_out);
        end else begin
          want = exp_q.pop_front();
          if (cur_out !== want) begin
            failures++;
            $display("FAIL rand_result: cycle %0d got acc/ovf/dbz/q/r=%0h expected %0h", cyc, cur_out, want);
          end
          if (want[9] || want[8]) exc_model++;
          delivered++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = cur_out;
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL rand_drain: got %0d undelivered expected 0", exp_q.size());
    end
    checks++;
    if (cnt_exc !== 8'((exc_model > 255) ? 255 : exc_model)) begin
      failures++; $display("FAIL rand_cnt: got %0d expected %0d", cnt_exc, (exc_model > 255) ? 255 : exc_model);
    end
    out_ready = 1'b0;
    $display("test_random: %0d results delivered, %0d exceptions", delivered, exc_model);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_exact();
    test_dbz();
    test_ovf();
    test_acc();
    test_back_to_back();
    test_reset_midflight();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
